// File: rtl/dmem_uart_responder_pkg.sv
// Shared definitions for the DMEM-mapped UART transmitter: register offsets
// (addr[3:2]), STATUS bit positions, serializer state type and a STATUS
// word packing helper.
package dmem_uart_responder_pkg;

   localparam logic [1:0] TXDATA_OFF  = 2'd0;
   localparam logic [1:0] STATUS_OFF  = 2'd1;
   localparam logic [1:0] BAUDDIV_OFF = 2'd2;

   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_BUSY    = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                               input logic busy, input logic ovf,
                                               input logic [4:0] count);
      logic [31:0] w;
      w                    = '0;
      w[STAT_FULL]         = full;
      w[STAT_EMPTY]        = empty;
      w[STAT_BUSY]         = busy;
      w[STAT_OVF]          = ovf;
      w[STAT_CNT_LSB +: 5] = count;
      return w;
   endfunction

endpackage

// File: rtl/dmem_uart_responder_if.sv
// DMEM Port B bus as seen by the UART responder.
//   addr  : byte address, driven every cycle
//   we    : byte-lane write enables (0 = no write)
//   wdata : lane-aligned store data
//   rdata : registered load data, valid one cycle after addr
//   sel_q : registered window hit, steers the external load-data mux
interface dmem_uart_responder_if;
   logic [31:0] addr;
   logic [3:0]  we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        sel_q;

   modport master (output addr, output we, output wdata, input rdata, input sel_q);
   modport slave  (input addr, input we, input wdata, output rdata, output sel_q);
endinterface

// File: rtl/dmem_uart_responder_tx_fifo.sv
// TX byte FIFO: circular buffer with naturally wrapping pointers.
//   push/push_data : write one byte (caller guarantees space or a same-cycle pop)
//   pop/pop_data   : pop_data shows the head entry; pop advances it
//   full/empty/count : occupancy, count is clog2(DEPTH)+1 bits
module tx_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW:0]   count_q, count_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= push_data;
   end

   assign pop_data = mem_q[rptr_q];
   assign full     = (count_q == (PW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
endmodule

// File: rtl/dmem_uart_responder.sv
// Memory-mapped 8N1 UART transmitter on DMEM Port B, BRAM-compatible timing.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : DMEM slave port (addr/we/wdata in, rdata/sel_q registered out)
//   tx         : serial output, idle high
// Registers (addr[3:2]): 0 TXDATA (W), 1 STATUS (R, ovf clear on write),
// 2 BAUDDIV (R/W, clocks per bit minus 1), 3 reserved.
module dmem_uart_responder
   import dmem_uart_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [15:0] BAUD_DIV_RST = 16'd867
) (
   input  logic                        clk,
   input  logic                        rst_n,
   dmem_uart_responder_if.slave        bus,
   output logic                        tx
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic           hit;
   logic [1:0]     off;
   logic           push_req, push_ok;
   logic           fifo_pop, fifo_full, fifo_empty;
   logic [7:0]     fifo_rdata;
   logic [CW-1:0]  fifo_count;
   logic           bit_end, start_frame, busy;

   tx_state_e      state_q, state_d;
   logic [15:0]    baud_cnt_q, baud_cnt_d;
   logic [15:0]    div_q, div_d;
   logic [15:0]    bauddiv_q, bauddiv_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q, tx_d;
   logic           ovf_q, ovf_d;
   logic           sel_q, sel_d;
   logic [31:0]    rdata_q, rdata_d;

   logic           unused_bits;
   assign unused_bits = ^{bus.addr[1:0], bus.we[3:2], bus.wdata[31:16]};

   assign hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign off      = bus.addr[3:2];
   assign push_req = hit && bus.we[0] && (off == TXDATA_OFF);
   // A full FIFO still accepts a byte when the serializer pops in the same cycle.
   assign push_ok  = push_req && (!fifo_full || fifo_pop);
   assign bit_end  = (baud_cnt_q == div_q);
   assign busy     = (state_q != TX_IDLE);

   tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_ok),
      .push_data (bus.wdata[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Serializer. STOP chains straight into START when more data is queued,
   // so back-to-back frames have no idle gap.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      div_d       = div_q;
      fifo_pop    = 1'b0;
      start_frame = 1'b0;
      case (state_q)
         TX_IDLE: start_frame = !fifo_empty;
         TX_START: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               state_d    = TX_DATA;
            end else baud_cnt_d = baud_cnt_q + 16'd1;
         end
         TX_DATA: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               shift_d    = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) state_d = TX_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else baud_cnt_d = baud_cnt_q + 16'd1;
         end
         TX_STOP: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (!fifo_empty) start_frame = 1'b1;
               else             state_d     = TX_IDLE;
            end else baud_cnt_d = baud_cnt_q + 16'd1;
         end
         default: state_d = TX_IDLE;
      endcase
      // BAUDDIV is sampled only here, so mid-frame writes apply to the next frame.
      if (start_frame) begin
         fifo_pop   = 1'b1;
         shift_d    = fifo_rdata;
         div_d      = bauddiv_q;
         baud_cnt_d = '0;
         bit_idx_d  = '0;
         state_d    = TX_START;
      end
      // tx is registered from the next state so it changes on the state edge.
      case (state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // Register file and BRAM-style registered read port.
   always_comb begin
      bauddiv_d = bauddiv_q;
      ovf_d     = ovf_q;
      if (push_req && !push_ok) ovf_d = 1'b1;
      if (hit && (off == STATUS_OFF) && bus.we[0] && bus.wdata[STAT_OVF]) ovf_d = 1'b0;
      if (hit && (off == BAUDDIV_OFF)) begin
         if (bus.we[0]) bauddiv_d[7:0]  = bus.wdata[7:0];
         if (bus.we[1]) bauddiv_d[15:8] = bus.wdata[15:8];
      end
      sel_d   = hit;
      rdata_d = '0;
      if (hit) begin
         case (off)
            STATUS_OFF:  rdata_d = pack_status(fifo_full, fifo_empty, busy, ovf_q, 5'(fifo_count));
            BAUDDIV_OFF: rdata_d = {16'h0000, bauddiv_q};
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= TX_IDLE;
         baud_cnt_q <= '0;
         div_q      <= '0;
         bauddiv_q  <= BAUD_DIV_RST;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         ovf_q      <= 1'b0;
         sel_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
         bauddiv_q  <= bauddiv_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ovf_q      <= ovf_d;
         sel_q      <= sel_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.sel_q = sel_q;
   assign tx        = tx_q;
endmodule

// File: tb/tb_dmem_uart_responder.sv
// Scoreboard bench for dmem_uart_responder. The reference model keeps a
// schedule of frames (start edge, stop edge, divisor, byte) and derives
// STATUS, read data and the expected tx level per clock edge arithmetically.
`timescale 1ns/1ps
module tb_dmem_uart_responder;
   localparam logic [31:0] BASE   = 32'h0001_0000;
   localparam int          DEPTH  = 8;
   localparam logic [15:0] BD_RST = 16'd867;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tx;

   dmem_uart_responder_if bus_if();

   dmem_uart_responder #(
      .BASE_ADDR    (BASE),
      .FIFO_DEPTH   (DEPTH),
      .BAUD_DIV_RST (BD_RST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int e; logic [31:0] rdata; logic sel; logic txv; } exp_t;
   typedef struct { int start; int stop; int div; logic [7:0] b; } frame_t;

   exp_t        exp_q[$];
   frame_t      pend[$];
   frame_t      last;
   logic [15:0] m_bd;
   logic        m_ovf;
   bit          in_rst;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv, input int e);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         if (n_bad <= 25) $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, expv);
      end
   endtask

   // Monitor: compares every registered output against the entry for this edge.
   always @(negedge clk) begin : monitor
      exp_t x;
      while (exp_q.size() > 0 && exp_q[0].e <= cyc) begin
         x = exp_q.pop_front();
         chk("rdata", bus_if.rdata, x.rdata, x.e);
         chk("sel_q", {31'b0, bus_if.sel_q}, {31'b0, x.sel}, x.e);
         chk("tx", {31'b0, tx}, {31'b0, x.txv}, x.e);
      end
   end

   task automatic model_reset();
      pend.delete();
      last  = '{start: 0, stop: 0, div: 0, b: 8'h00};
      m_bd  = BD_RST;
      m_ovf = 1'b0;
   endtask

   function automatic logic tx_of(input frame_t f, input int e);
      int bitn;
      if (e < f.start || e >= f.stop) return 1'b1;
      bitn = (e - f.start) / (f.div + 1);
      if (bitn == 0) return 1'b0;
      if (bitn <= 8) return f.b[bitn-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] miss_addr();
      logic [31:0] a;
      a = $urandom;
      if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
      return a;
   endfunction

   // Drives one bus cycle (sampled at the next edge) and queues its expectation.
   task automatic do_cycle(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      int          k, e, cnt, tail;
      bit          hit, pop_now, busy;
      logic [1:0]  off;
      logic [31:0] rd;
      exp_t        x;
      frame_t      f;
      bus_if.addr  = a;
      bus_if.we    = w;
      bus_if.wdata = d;
      k = cyc;
      e = k + 1;
      x.e = e;
      if (in_rst) begin
         model_reset();
         x.rdata = '0; x.sel = 1'b0; x.txv = 1'b1;
      end else begin
         while (pend.size() > 0 && pend[0].start <= k) last = pend.pop_front();
         cnt  = pend.size();
         busy = (last.start <= k) && (k < last.stop);
         hit  = (a[31:4] == BASE[31:4]);
         off  = a[3:2];
         rd   = '0;
         if (hit && off == 2'd1) begin
            rd[0]   = (cnt == DEPTH);
            rd[1]   = (cnt == 0);
            rd[2]   = busy;
            rd[3]   = m_ovf;
            rd[8:4] = 5'(cnt);
         end
         if (hit && off == 2'd2) rd = {16'h0000, m_bd};
         pop_now = (cnt > 0) && (pend[0].start == e);
         if (hit && off == 2'd0 && w[0]) begin
            if (cnt < DEPTH || pop_now) begin
               tail    = (cnt > 0) ? pend[cnt-1].stop : last.stop;
               f.start = (e + 1 > tail) ? e + 1 : tail;
               f.div   = int'(m_bd);
               f.stop  = f.start + 10 * (f.div + 1);
               f.b     = d[7:0];
               pend.push_back(f);
            end else m_ovf = 1'b1;
         end
         if (hit && off == 2'd1 && w[0] && d[3]) m_ovf = 1'b0;
         if (hit && off == 2'd2) begin
            if (w[0]) m_bd[7:0]  = d[7:0];
            if (w[1]) m_bd[15:8] = d[15:8];
         end
         x.rdata = rd;
         x.sel   = hit;
         x.txv   = (pend.size() > 0 && pend[0].start <= e) ? tx_of(pend[0], e) : tx_of(last, e);
      end
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      do_cycle(miss_addr(), 4'($urandom), $urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((pend.size() > 0 || last.stop > cyc) && n < 3000) begin
         idle_cycle();
         n++;
      end
      if (n >= 3000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_wait: transmitter still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic apply_reset(input int n);
      exp_t x;
      in_rst = 1'b1;
      model_reset();
      bus_if.addr = miss_addr(); bus_if.we = 4'h0; bus_if.wdata = '0;
      x.e = cyc + 1; x.rdata = '0; x.sel = 1'b0; x.txv = 1'b1;
      exp_q.push_back(x);
      #5 rst_n = 1'b0;
      #1 chk("tx_on_reset", {31'b0, tx}, 32'h1, cyc);
      @(posedge clk);
      #1;
      repeat (n) do_cycle(miss_addr(), 4'h0, '0);
      rst_n  = 1'b1;
      in_rst = 1'b0;
   endtask

   task automatic rand_op();
      int unsigned r;
      logic [31:0] d;
      logic [3:0]  w;
      r = $urandom_range(0, 99);
      d = $urandom;
      w = 4'($urandom);
      if (r < 35) begin
         if ($urandom_range(0, 9) != 0) w[0] = 1'b1;
         do_cycle(BASE | 32'($urandom_range(0, 3)), w, d);
      end else if (r < 50) do_cycle(BASE + 32'h4, 4'h0, d);
      else if (r < 58)     do_cycle(BASE + 32'h4 + 32'($urandom_range(0, 3)), w, d);
      else if (r < 66)     do_cycle(BASE + 32'h8, 4'h0, d);
      else if (r < 72) begin
         if (pend.size() == 0 || pend[$].start <= cyc) begin
            d[15:8] = 8'h00;
            d[7:0]  = 8'($urandom_range(0, 3));
            do_cycle(BASE + 32'h8, w, d);
         end else do_cycle(BASE + 32'h8, 4'h0, d);
      end
      else if (r < 78)     do_cycle(BASE + 32'hC, w, d);
      else if (r < 82)     do_cycle(BASE, 4'h0, d);
      else                 idle_cycle();
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bus_if.addr  = '0;
      bus_if.we    = 4'h0;
      bus_if.wdata = '0;
      in_rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      repeat (3) do_cycle(miss_addr(), 4'h0, '0);
      rst_n  = 1'b1;
      in_rst = 1'b0;

      // Reset state read of STATUS.
      do_cycle(BASE + 32'h4, 4'h0, '0);
      idle_cycle();

      // Single 0xA5 frame at 4 clocks per bit.
      do_cycle(BASE + 32'h8, 4'b0011, 32'h0000_0003);
      do_cycle(BASE, 4'b0001, 32'h0000_00A5);
      do_cycle(BASE + 32'h4, 4'h0, '0);
      wait_idle();

      // Fill to overflow at 1 clock per bit, then clear ovf.
      do_cycle(BASE + 32'h8, 4'b0011, 32'h0000_0000);
      for (int i = 0; i < 10; i++) do_cycle(BASE, 4'b0001, 32'(8'h30 + i));
      do_cycle(BASE + 32'h4, 4'h0, '0);
      do_cycle(BASE + 32'h4, 4'b0001, 32'h0000_0008);
      do_cycle(BASE + 32'h4, 4'h0, '0);
      wait_idle();

      // Byte-lane store into BAUDDIV upper byte.
      do_cycle(BASE + 32'h8, 4'b0011, 32'h0000_0003);
      do_cycle(BASE + 32'h9, 4'b0010, 32'h0000_1200);
      do_cycle(BASE + 32'h8, 4'h0, '0);
      do_cycle(BASE + 32'h8, 4'b0011, 32'h0000_0001);

      // Out-of-window full-word store has no effect.
      do_cycle(32'h0002_0004, 4'hF, 32'hFFFF_FFFF);
      do_cycle(32'h0002_0000, 4'hF, 32'h0000_0055);
      do_cycle(BASE + 32'h4, 4'h0, '0);
      do_cycle(BASE + 32'h8, 4'h0, '0);

      for (int i = 0; i < 2500; i++) rand_op();
      wait_idle();

      // Reset while a 0x00 frame is in its data bits.
      do_cycle(BASE + 32'h8, 4'b0011, 32'h0000_0003);
      do_cycle(BASE, 4'b0001, 32'h0000_0000);
      repeat (16) idle_cycle();
      apply_reset(3);
      do_cycle(BASE + 32'h4, 4'h0, '0);
      repeat (60) idle_cycle();

      @(negedge clk);
      #1;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'h0, cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dmem_uart_responder.md
Name: dmem_uart_responder

Overview:
- Memory-mapped UART transmitter that answers the core's data-memory port (DMEM, Port B) inside a fixed address window, alongside the data BRAM.
- Timing matches the BRAM exactly: stores commit on the clock edge; load data appears on `rdata` one cycle after the address, so the MEM stage consumes it unchanged.
- Contains a TX byte FIFO, a baud divider and an 8N1 serializer.

Parameters:
- BASE_ADDR, 32'h0001_0000, base of the 16-byte register window.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, range 2..16.
- BAUD_DIV_RST, 16'd867, reset value of BAUDDIV (clocks per bit minus 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  32  byte address from the core ALU result; driven every cycle
- we  in  4  byte-lane write enables from the store formatter; 0 means no write
- wdata  in  32  lane-aligned store data
- rdata  out  32  registered read data, valid one cycle after `addr`
- sel_q  out  1  registered "previous address hit the window", for the external load-data mux
- tx  out  1  serial output, idle high

Behaviour:
- Address decode
  - `hit = (addr[31:4] == BASE_ADDR[31:4])`.
  - Register offset is `addr[3:2]`; `addr[1:0]` is ignored.
  - No access (read or write) has side effects unless `hit` is high.
- Register map
  - 0x0 TXDATA (W): `we[0]` pushes `wdata[7:0]` into the FIFO. Reads return 0.
  - 0x4 STATUS (R):
    - bit0 full, bit1 empty, bit2 busy, bit3 ovf (sticky)
    - bits[8:4] count, zero-extended
    - all other bits 0
    - Writing with `we[0]` and `wdata[3]=1` clears ovf.
  - 0x8 BAUDDIV (R/W): 16 bits; `we[0]` writes [7:0], `we[1]` writes [15:8]; upper bits read 0.
  - 0xC: reads 0, writes ignored.
- Reads
  - `rdata <= hit ? reg(offset) : 0` every clock. Reads have no side effects, because the address is driven speculatively.
  - `sel_q <= hit`.
  - Read-after-write to the same register in consecutive cycles returns the new value (the register updates at edge N; the read issued in cycle N+1 samples it).
- FIFO
  - Circular buffer; read/write pointers are clog2(FIFO_DEPTH) bits and wrap naturally; count is clog2+1 bits.
  - A push is accepted if `!full`, or if a pop occurs in the same cycle.
  - A rejected push sets ovf and leaves the FIFO unchanged.
  - Push into an empty FIFO while the serializer is idle: the byte is popped on the next edge.
- Serializer FSM (IDLE, START, DATA, STOP)
  - IDLE: `tx=1`. If the FIFO is not empty, pop a byte into the shift register, latch BAUDDIV into `div_q`, load the bit counter with 0, go to START.
  - Each state lasts `div_q+1` clocks, timed by the baud counter.
  - START: `tx=0`, then go to DATA with bit index 0.
  - DATA: `tx = shift[0]` (LSB first). After 8 bits go to STOP.
  - STOP: `tx=1` for one bit time. Then go to START directly if the FIFO is not empty (back-to-back frames, no extra idle), else IDLE.
  - busy is high in START, DATA and STOP.
  - A BAUDDIV write mid-frame takes effect at the next frame start.
  - BAUDDIV=0 gives 1 clock per bit.
- Reset (asynchronous, any time, including mid-frame)
  - `rdata=0`, `sel_q=0`, `tx=1`, FSM to IDLE
  - FIFO emptied (pointers and count 0), ovf=0
  - BAUDDIV=BAUD_DIV_RST
  - A frame in progress is aborted, with no glitch low on `tx`.

Decomposition:
- Shared package `mmio_pkg`: register offsets (TXDATA_OFF, STATUS_OFF, BAUDDIV_OFF), STATUS bit indices, TX FSM state encoding (2-bit localparams).
- One natural sub-module: `tx_fifo` (parameterised depth, push/pop/full/empty/count, simultaneous push+pop).
- Decode, registers and serializer stay in the top module.

Test Plan:
- Reset, then read 0x0001_0004: `rdata`=0x0000_0002 one cycle later, `sel_q`=1; `tx` held 1.
- Write BAUDDIV=3, then TXDATA=0xA5:
  - `tx` shows start bit 0 for 4 clocks.
  - Then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop bit 1.
  - Frame totals 40 clocks.
- BAUDDIV=0, nine back-to-back TXDATA writes with FIFO_DEPTH=8:
  - First byte popped immediately; the remaining 8 fill the FIFO. No overflow.
  - A tenth write sets ovf: STATUS bit3=1, full=1.
  - Write STATUS with 0x8: ovf clears.
  - All 9 frames transmit contiguously, no idle between them.
- Byte store with `we`=4'b0010 to BAUDDIV at 0x0001_0009: only [15:8] changes. Read back BAUDDIV=0x1203 after first writing 0x0003 then storing 0x12 on lane 1.
- Address 0x0002_0004 with `we`=4'hF: no register change, `rdata`=0, `sel_q`=0.
- Assert `rst_n` low mid-DATA: `tx`=1 immediately; after release STATUS=0x2 and no residual frame is sent.
